// File: rtl/ucaspian_axon_if.sv
// ucaspian_axon_if: fire input and synapse output handshake bundle
interface ucaspian_axon_if;
    logic [7:0]  axon_addr;
    logic        axon_vld;
    logic        axon_rdy;
    logic [11:0] synapse_addr;
    logic        synapse_vld;
    logic        synapse_rdy;
    modport master(output axon_addr, axon_vld, synapse_rdy, input axon_rdy, synapse_addr, synapse_vld);
    modport slave(input axon_addr, axon_vld, synapse_rdy, output axon_rdy, synapse_addr, synapse_vld);
endinterface

// File: rtl/ucaspian_axon.sv
// ucaspian_axon: queues neuron fires and expands each into its run of synapse addresses
module ucaspian_axon #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        clear_act,
    input  logic        clear_config,
    output logic        clear_done,
    input  logic [7:0]  config_addr,
    input  logic [11:0] config_value,
    input  logic [2:0]  config_byte,
    input  logic        config_enable,
    output logic        step_done,
    ucaspian_axon_if.slave ax
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH - 1);
    typedef enum logic [2:0] {IDLE, LOOKUP, LOAD, EMIT, CLEAR} state_t;
    state_t state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [11:0]   addr_q, addr_d, base_q, base_d, start_tmp_q, start_tmp_d;
    logic [7:0]    rem_q, rem_d, clr_cnt_q, clr_cnt_d;
    logic          vld_q, vld_d, done_q, done_d, step_q, step_d;
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [19:0]   cfg_mem [256];
    logic [19:0]   cfg_rd_q, cfg_wd;
    logic [7:0]    cfg_wa;
    logic          cfg_we, clr, push, pop;
    assign clr = clear_act | clear_config;
    assign ax.axon_rdy = ~clr && (cnt_q < FULL);
    assign push = ax.axon_vld && ax.axon_rdy;
    assign ax.synapse_addr = addr_q;
    assign ax.synapse_vld = vld_q;
    assign clear_done = done_q;
    assign step_done = step_q;
    always_comb begin
        cfg_we = clear_config ? (state_q == CLEAR) : (~clr && config_enable && config_byte == 3'd2);
        cfg_wa = clear_config ? clr_cnt_q : config_addr;
        cfg_wd = clear_config ? 20'd0 : {config_value[7:0], start_tmp_q};
        start_tmp_d = (~clr && config_enable && config_byte == 3'd1) ? config_value : start_tmp_q;
        state_d = state_q;
        addr_d = addr_q;
        vld_d = vld_q;
        base_d = base_q;
        rem_d = rem_q;
        clr_cnt_d = 8'd0;
        done_d = 1'b0;
        pop = 1'b0;
        if (clr) begin
            state_d = CLEAR;
            vld_d = 1'b0;
            // sweep starts the cycle after entry, done latches once 255 has been visited
            if (state_q == CLEAR) begin
                clr_cnt_d = clr_cnt_q + 8'd1;
                done_d = done_q | (clr_cnt_q == 8'hFF);
            end
        end else begin
            case (state_q)
                IDLE: if (enable && cnt_q != '0) begin
                    pop = 1'b1;
                    state_d = LOOKUP;
                end
                LOOKUP: begin
                    base_d = cfg_rd_q[11:0];
                    rem_d = cfg_rd_q[19:12];
                    state_d = LOAD;
                end
                LOAD: if (rem_q == 8'd0) state_d = IDLE;
                else begin
                    addr_d = base_q;
                    vld_d = 1'b1;
                    state_d = EMIT;
                end
                EMIT: if (ax.synapse_rdy) begin
                    if (rem_q == 8'd1) begin
                        vld_d = 1'b0;
                        state_d = IDLE;
                    end else begin
                        addr_d = addr_q + 12'd1;
                        rem_d = rem_q - 8'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        wr_ptr_d = clr ? '0 : wr_ptr_q + AW'(push);
        rd_ptr_d = clr ? '0 : rd_ptr_q + AW'(pop);
        cnt_d = clr ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        step_d = cnt_q == '0 && state_q == IDLE && ~ax.axon_vld && ~vld_q && ~clr;
    end
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= ax.axon_addr;
        if (cfg_we) cfg_mem[cfg_wa] <= cfg_wd;
        cfg_rd_q <= cfg_mem[fifo_mem[rd_ptr_q]];
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q <= '0;
            addr_q <= 12'd0;
            base_q <= 12'd0;
            start_tmp_q <= 12'd0;
            rem_q <= 8'd0;
            clr_cnt_q <= 8'd0;
            vld_q <= 1'b0;
            done_q <= 1'b0;
            step_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q <= cnt_d;
            addr_q <= addr_d;
            base_q <= base_d;
            start_tmp_q <= start_tmp_d;
            rem_q <= rem_d;
            clr_cnt_q <= clr_cnt_d;
            vld_q <= vld_d;
            done_q <= done_d;
            step_q <= step_d;
        end
    end
endmodule

// File: tb/tb_ucaspian_axon.sv
// tb_ucaspian_axon: scoreboard bench for fire expansion, stalls, clear and enable gating
module tb_ucaspian_axon;
    logic clk = 0, reset, enable, clear_act, clear_config, clear_done, config_enable, step_done;
    logic [7:0] config_addr;
    logic [11:0] config_value;
    logic [2:0] config_byte;
    int total = 0, bad = 0;
    logic [11:0] m_start [256];
    logic [7:0]  m_count [256];
    logic [11:0] sb [$];
    logic last_vld = 0, last_rdy = 0, last_hold = 1;
    logic [11:0] last_addr = 0;
    ucaspian_axon_if bus();
    ucaspian_axon dut (.clk(clk), .reset(reset), .enable(enable), .clear_act(clear_act),
        .clear_config(clear_config), .clear_done(clear_done), .config_addr(config_addr),
        .config_value(config_value), .config_byte(config_byte), .config_enable(config_enable),
        .step_done(step_done), .ax(bus.slave));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic cfg(input logic [7:0] n, input logic [11:0] start, input logic [7:0] count);
        config_enable = 1; config_addr = n; config_byte = 3'd1; config_value = start;
        tick();
        config_byte = 3'd2; config_value = {4'd0, count};
        tick();
        config_enable = 0; config_byte = 3'd0;
        m_start[n] = start; m_count[n] = count;
    endtask
    task automatic fire(input logic [7:0] n);
        chk("axon_rdy_before_fire", bus.axon_rdy, 1);
        bus.axon_vld = 1; bus.axon_addr = n;
        tick();
        bus.axon_vld = 0;
        for (int i = 0; i < m_count[n]; i++) sb.push_back(m_start[n] + 12'(i));
    endtask
    task automatic drain();
        int k = 0;
        while (!(step_done && sb.size() == 0) && k < 600) begin tick(); k++; end
        chk("drain_timeout", k < 600, 1);
    endtask
    always @(negedge clk) begin
        if (!reset && bus.synapse_vld && bus.synapse_rdy) begin
            if (sb.size() == 0) chk("unexpected_vld", bus.synapse_addr, 32'hFFFF_FFFF);
            else chk("syn_addr", bus.synapse_addr, sb.pop_front());
        end
        if (!reset && last_vld && !last_rdy && !last_hold) begin
            chk("stall_vld", bus.synapse_vld, 1);
            chk("stall_addr", bus.synapse_addr, last_addr);
        end
        last_vld = bus.synapse_vld; last_rdy = bus.synapse_rdy; last_addr = bus.synapse_addr;
        last_hold = reset | clear_act | clear_config;
    end
    initial begin
        reset = 1; enable = 1; clear_act = 0; clear_config = 0; config_enable = 0;
        config_addr = 0; config_value = 0; config_byte = 0;
        bus.axon_vld = 0; bus.axon_addr = 0; bus.synapse_rdy = 1;
        for (int i = 0; i < 256; i++) begin m_start[i] = 0; m_count[i] = 0; end
        tick(); tick();
        chk("rst_axon_rdy", bus.axon_rdy, 1);
        chk("rst_syn_vld", bus.synapse_vld, 0);
        chk("rst_syn_addr", bus.synapse_addr, 0);
        chk("rst_clear_done", clear_done, 0);
        chk("rst_step_done", step_done, 0);
        reset = 0;
        clear_act = 1;
        repeat (3) tick();
        clear_act = 0;
        tick();
        cfg(5, 12'h100, 3); cfg(9, 12'hFFE, 4); cfg(7, 12'h555, 0);
        repeat (2) tick();
        fire(5);
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk($sformatf("lat_vld_%0d", k), bus.synapse_vld, (k >= 3 && k <= 5));
        end
        repeat (2) tick();
        chk("step_done_idle", step_done, 1);
        fire(9);
        drain();
        fire(7); fire(5);
        drain();
        bus.synapse_rdy = 0;
        for (int i = 0; i < 16; i++) fire(i[0] ? 8'd9 : 8'd5);
        chk("axon_rdy_full", bus.axon_rdy, 0);
        bus.axon_vld = 1; bus.axon_addr = 8'd9;
        for (int k = 0; k < 4; k++) begin tick(); chk("axon_rdy_held", bus.axon_rdy, 0); end
        bus.axon_vld = 0;
        repeat (6) tick();
        chk("stall_head_vld", bus.synapse_vld, 1);
        chk("stall_head_addr", bus.synapse_addr, 12'h100);
        bus.synapse_rdy = 1;
        drain();
        bus.synapse_rdy = 0;
        fire(9);
        begin
            int k = 0;
            while (!bus.synapse_vld && k < 20) begin tick(); k++; end
            chk("emit_wait", bus.synapse_vld, 1);
        end
        clear_config = 1;
        sb.delete();
        for (int n = 1; n <= 300; n++) begin
            tick();
            if (n == 1) chk("clr_vld_off", bus.synapse_vld, 0);
            if (n == 2) chk("clr_axon_rdy", bus.axon_rdy, 0);
            if (n == 256) chk("clr_done_256", clear_done, 0);
            if (n == 257) chk("clr_done_257", clear_done, 1);
            if (n == 300) chk("clr_done_300", clear_done, 1);
        end
        clear_config = 0;
        for (int i = 0; i < 256; i++) begin m_start[i] = 0; m_count[i] = 0; end
        tick();
        chk("clr_done_drop", clear_done, 0);
        bus.synapse_rdy = 1;
        fire(5);
        drain();
        cfg(5, 12'h100, 3); cfg(9, 12'hFFE, 4);
        enable = 0;
        fire(5); fire(9);
        for (int k = 0; k < 5; k++) begin tick(); chk("en_off_vld", bus.synapse_vld, 0); end
        chk("en_off_step", step_done, 0);
        enable = 1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk($sformatf("en_lat_%0d", k), bus.synapse_vld, (k == 3));
        end
        drain();
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
